lfsr32_hex_source: RTL

Upstream source for the eight-digit hex display path on the DE2-115 board. The block holds a 32-bit Fibonacci LFSR and advances it on a debounced KEY press or, when compiled in, on a periodic auto-run tick. It supports seed loading from an input bus. Its 32-bit state is presented as eight nibbles, one per hex-digit decoder (HEX7..HEX0), with a one-cycle update strobe.

---
 rtl/lfsr32_pkg.sv | 25 ++
 rtl/lfsr32_hex_source_if.sv | 20 ++
 rtl/key_debounce.sv | 59 +++++
 rtl/lfsr32_hex_source.sv | 120 ++++++++++++
 4 files changed

// File: rtl/lfsr32_pkg.sv
// Shared constants and the LFSR step function for the hex-display LFSR source.
package lfsr32_pkg;

   localparam int TAP_A = 31;
   localparam int TAP_B = 21;
   localparam int TAP_C = 1;
   localparam int TAP_D = 0;

   localparam logic [31:0] ZERO_SEED_FIX      = 32'h0000_0001;
   localparam logic [31:0] DEFAULT_RESET_SEED = 32'hACE1_0001;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_LOAD = 2'd1,
      EV_STEP = 2'd2
   } lfsr_event_e;

   // x^32 + x^22 + x^2 + x + 1, shifting toward the MSB
   function automatic logic [31:0] lfsr_next(input logic [31:0] q);
      logic fb;
      fb = q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D];
      return {q[30:0], fb};
   endfunction

endpackage

// File: rtl/lfsr32_hex_source_if.sv
// Key, seed and display-side signals of lfsr32_hex_source bundled as one port.
interface lfsr32_hex_source_if;
   logic        step_key_n;
   logic        load_key_n;
   logic [31:0] seed_i;
   logic        run_i;
   logic [31:0] lfsr_q;
   logic        upd_o;
   logic        seed_fix_o;

   modport master (
      output step_key_n, load_key_n, seed_i, run_i,
      input  lfsr_q, upd_o, seed_fix_o
   );

   modport slave (
      input  step_key_n, load_key_n, seed_i, run_i,
      output lfsr_q, upd_o, seed_fix_o
   );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchronizer, level debouncer and registered press pulse for one
// active-low KEY input.
module key_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

   logic [1:0]    sync_r;
   logic          level_r;
   logic [CW-1:0] cnt_r;
   logic          press_r;

   logic          level_nxt_s;
   logic [CW-1:0] cnt_nxt_s;
   logic          press_nxt_s;

   // synchronizer, accepted level, stability counter and press pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r  <= 2'b11;
         level_r <= 1'b1;
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else begin
         sync_r  <= {sync_r[0], key_n};
         level_r <= level_nxt_s;
         cnt_r   <= cnt_nxt_s;
         press_r <= press_nxt_s;
      end
   end

   // count while the synchronized level disagrees; flip and flag presses on expiry
   always_comb begin
      level_nxt_s = level_r;
      cnt_nxt_s   = cnt_r;
      press_nxt_s = 1'b0;
      if (sync_r[1] != level_r) begin
         if (cnt_r == DEB_LAST) begin
            level_nxt_s = sync_r[1];
            cnt_nxt_s   = '0;
            press_nxt_s = level_r;
         end else begin
            cnt_nxt_s   = cnt_r + CW'(1);
         end
      end else begin
         cnt_nxt_s = '0;
      end
   end

   assign press = press_r;

endmodule

// File: rtl/lfsr32_hex_source.sv
// 32-bit Fibonacci LFSR stepped by a debounced KEY and seeded from a bus.
// Optional auto-run prescaler enabled by defining LFSR_AUTO_RUN_EN.
module lfsr32_hex_source
   import lfsr32_pkg::*;
#(
   parameter int          CLK_HZ       = 50_000_000,
   parameter int          DEB_CYCLES   = CLK_HZ / 100,
   parameter int          AUTO_STEP_HZ = 4,
   parameter logic [31:0] RESET_SEED   = DEFAULT_RESET_SEED
) (
   input logic                  clk,
   input logic                  rst_n,
   lfsr32_hex_source_if.slave   bus
);

   // a zero reset seed would lock the register, so it is swapped like a zero load
   localparam logic [31:0] RESET_VALUE = (RESET_SEED == 32'h0000_0000) ? ZERO_SEED_FIX : RESET_SEED;

   logic        step_press_s;
   logic        load_press_s;
   logic        tick_s;
   logic        step_s;
   lfsr_event_e ev_s;
   logic [31:0] lfsr_nxt_s;
   logic        fix_nxt_s;

   logic [31:0] lfsr_r;
   logic        upd_r;
   logic        fix_r;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.step_key_n),
      .press (step_press_s)
   );

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_load_key (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (bus.load_key_n),
      .press (load_press_s)
   );

`ifdef LFSR_AUTO_RUN_EN
   localparam int PRESC_MAX = (CLK_HZ / AUTO_STEP_HZ) - 1;
   localparam int PW        = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_MAX);

   logic [PW-1:0] presc_r;

   // prescaler: free-runs while enabled, parked at zero otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_r <= '0;
      end else if (!bus.run_i || presc_r == PRESC_LAST) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   assign tick_s = bus.run_i && (presc_r == PRESC_LAST);
`else
   localparam int unused_rate_p = CLK_HZ / AUTO_STEP_HZ;
   logic unused_run_s;
   assign unused_run_s = bus.run_i;
   assign tick_s       = 1'b0;
`endif

   assign step_s = step_press_s | tick_s;

   // load beats step; a step arriving with a load is dropped
   always_comb begin
      ev_s       = EV_NONE;
      lfsr_nxt_s = lfsr_r;
      fix_nxt_s  = fix_r;
      if (load_press_s) begin
         ev_s = EV_LOAD;
      end else if (step_s) begin
         ev_s = EV_STEP;
      end else begin
         ev_s = EV_NONE;
      end
      case (ev_s)
         EV_LOAD: begin
            if (bus.seed_i == 32'h0000_0000) begin
               lfsr_nxt_s = ZERO_SEED_FIX;
               fix_nxt_s  = 1'b1;
            end else begin
               lfsr_nxt_s = bus.seed_i;
               fix_nxt_s  = 1'b0;
            end
         end
         EV_STEP: lfsr_nxt_s = lfsr_next(lfsr_r);
         default: begin
            lfsr_nxt_s = lfsr_r;
            fix_nxt_s  = fix_r;
         end
      endcase
   end

   // state, update strobe and zero-seed flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= RESET_VALUE;
         upd_r  <= 1'b0;
         fix_r  <= 1'b0;
      end else begin
         lfsr_r <= lfsr_nxt_s;
         upd_r  <= (ev_s != EV_NONE);
         fix_r  <= fix_nxt_s;
      end
   end

   assign bus.lfsr_q     = lfsr_r;
   assign bus.upd_o      = upd_r;
   assign bus.seed_fix_o = fix_r;

endmodule
